kernel_status_led_ctrl: RTL
===========================

Name: kernel_status_led_ctrl

Overview:
Board-level status controller that sits between the board pins and one or more kernel wrappers. It generalises the single-kernel reset/LED glue to NUM_CH kernels:
- reset synchroniser with parametrised depth, driving the kernels' active-low reset;
- per-channel sticky done/overrun tracking with LED drive and saturating completion counters;
- debounced clear button;
- heartbeat LED.

Parameters:
NUM_CH, 4, number of kernel channels (1..16)
SYNC_STAGES, 3, reset synchroniser depth (>=2)
CNT_W, 8, width of each per-channel completion counter
DEBOUNCE_CYCLES, 65536, cycles the clear input must be stable before it is accepted (>=2)
BLINK_DIV_LOG2, 24, width of the free-running blink/heartbeat divider

Ports:
i_clk  input  1  system clock; kernels share this domain
reset_button  input  1  asynchronous active-low reset (board pin)
i_irq  input  NUM_CH  per-kernel done irq, level, same clock domain
i_clear_n  input  1  raw clear button, active-low, asynchronous to i_clk
o_kernel_reset_n  output  1  synchronised active-low reset to the kernel wrappers
fpga_led  output  NUM_CH  per-channel status LED, registered
o_heartbeat_led  output  1  divider MSB, registered
o_all_done  output  1  high when every channel is DONE or OVERRUN, registered
o_done_count  output  NUM_CH*CNT_W  packed per-channel completion counts; channel k occupies bits [k*CNT_W +: CNT_W]

Behaviour:
- Reset synchroniser:
  - reset_button low asynchronously clears all SYNC_STAGES flops.
  - Deassertion shifts a 1 through; the last stage is rst_n_sync.
  - o_kernel_reset_n = rst_n_sync, so it rises on the SYNC_STAGES-th i_clk edge after reset_button rises.
- All other state uses rst_n_sync: asynchronous assert, synchronous release.
- Reset values: fpga_led=0, o_heartbeat_led=0, o_all_done=0, o_done_count=0, all channels CH_IDLE, divider=0, debouncer idle (stable level = 1).
- Reset mid-operation: every output returns to its reset value immediately, with no clock required.
- Irq edge detect:
  - irq_q <= i_irq; irq_q2 <= irq_q; ev[k] = irq_q[k] & ~irq_q2[k].
  - A level held high produces exactly one event.
- Per-channel FSM, evaluated each cycle:
  - CH_IDLE: ev -> CH_DONE.
  - CH_DONE: ev -> CH_OVERRUN.
  - CH_OVERRUN: ev -> stays CH_OVERRUN.
  - clr pulse moves any state to CH_IDLE.
  - clr and ev in the same cycle: result is CH_DONE (clear applied first, then the event).
- Counter: increments on each ev and saturates at 2^CNT_W-1. The clear button does not affect counters; only reset clears them.
- LED: CH_IDLE -> 0, CH_DONE -> 1, CH_OVERRUN -> blink phase (divider MSB).
  - All outputs are registered from state, adding one cycle.
- Latency: let E0 be the first i_clk edge sampling i_irq[k]=1.
  - Counter and state update at E1.
  - fpga_led[k] and o_all_done reflect the new state after E2.
- Debouncer:
  - 2-flop synchroniser on i_clear_n.
  - A stable counter restarts on any change of the synchronised level.
  - After DEBOUNCE_CYCLES consecutive equal samples, the new level is accepted.
  - An accepted 1->0 transition emits a one-cycle clr pulse. Release (0->1) emits nothing.
  - Holding the button produces a single pulse. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Divider: free-running BLINK_DIV_LOG2-bit counter that wraps at all-ones -> 0. o_heartbeat_led <= divider MSB.
- NUM_CH=1 must elaborate; o_all_done then equals the single channel's DONE/OVERRUN status.

Decomposition:
- Package kernel_status_pkg:
  - ch_state_t, a 2-bit enum {CH_IDLE=0, CH_DONE=1, CH_OVERRUN=2}, with encoding 3 illegal and recovering to CH_IDLE;
  - a localparam for the irq pipeline depth (2);
  - a function for saturating increment.
- Sub-module button_debounce (params DEBOUNCE_CYCLES; ports i_clk, rst_n, i_btn_n, o_press_pulse).
- The reset synchroniser stays inline.

Test Plan:
All scenarios use NUM_CH=4, CNT_W=4, DEBOUNCE_CYCLES=16, BLINK_DIV_LOG2=4.
1. Reset release: reset_button 0->1 -> o_kernel_reset_n rises exactly 3 edges later; all other outputs 0 throughout reset.
2. Single done: i_irq[2] high for 10 cycles from E0 -> count[2]=1 at E1, fpga_led=4'b0100 after E2, held; other counts 0.
3. Overrun and saturation: 20 separate pulses on i_irq[0] -> fpga_led[0] toggles every 8 cycles, count[0]=15 (saturated); all four channels pulsed -> o_all_done=1.
4. Debounce: i_clear_n low for 10 cycles -> no clear. Low for 40 cycles -> exactly one clr; all LEDs 0, o_all_done 0, counts unchanged.
5. Simultaneous: clr pulse coincident with ev[1] while ch1 is OVERRUN -> ch1 is CH_DONE, fpga_led[1]=1 steady, count[1] incremented.
6. Async reset mid-run: reset_button low between clock edges with LEDs lit -> fpga_led, counts and o_kernel_reset_n read 0 before the next edge.

Source files
------------

// File: rtl/kernel_status_led_ctrl_pkg.sv
// Shared types and helpers for the kernel status / LED controller.
package kernel_status_pkg;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_DONE    = 2'd1,
    CH_OVERRUN = 2'd2
  } ch_state_t;

  localparam int IRQ_PIPE_DEPTH = 2;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/kernel_status_led_ctrl_button_debounce.sv
// Clear-button debouncer: 2-flop sync, stability counter, one pulse per accepted press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic i_clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_press_pulse
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    btn_sync;
  logic          sample;
  logic          level;
  logic [CW-1:0] stable_cnt;

  assign sample = btn_sync[1];

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync      <= 2'b11;
      level         <= 1'b1;
      stable_cnt    <= '0;
      o_press_pulse <= 1'b0;
    end else begin
      btn_sync      <= {btn_sync[0], i_btn_n};
      o_press_pulse <= 1'b0;
      // Counter only runs while the synced level disagrees with the accepted one.
      if (sample == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level         <= sample;
        stable_cnt    <= '0;
        o_press_pulse <= ~sample;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/kernel_status_led_ctrl.sv
// Board status glue: reset sync, per-channel done/overrun tracking, LEDs, counters, heartbeat.
module kernel_status_led_ctrl
  import kernel_status_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 3,
  parameter int CNT_W           = 8,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int BLINK_DIV_LOG2  = 24
) (
  input  logic                    i_clk,
  input  logic                    reset_button,
  input  logic [NUM_CH-1:0]       i_irq,
  input  logic                    i_clear_n,
  output logic                    o_kernel_reset_n,
  output logic [NUM_CH-1:0]       fpga_led,
  output logic                    o_heartbeat_led,
  output logic                    o_all_done,
  output logic [NUM_CH*CNT_W-1:0] o_done_count
);

  logic [SYNC_STAGES-1:0] rst_sync;
  logic                   rst_n_sync;

  always_ff @(posedge i_clk or negedge reset_button) begin
    if (!reset_button) rst_sync <= '0;
    else               rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_n_sync       = rst_sync[SYNC_STAGES-1];
  assign o_kernel_reset_n = rst_n_sync;

  logic [BLINK_DIV_LOG2-1:0] div;
  logic                      blink;

  always_ff @(posedge i_clk or negedge rst_n_sync) begin
    if (!rst_n_sync) div <= '0;
    else             div <= div + 1'b1;
  end

  assign blink = div[BLINK_DIV_LOG2-1];

  logic clr;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .i_clk        (i_clk),
    .rst_n        (rst_n_sync),
    .i_btn_n      (i_clear_n),
    .o_press_pulse(clr)
  );

  logic [IRQ_PIPE_DEPTH-1:0][NUM_CH-1:0] irq_pipe;
  logic [NUM_CH-1:0]                     ev;

  always_ff @(posedge i_clk or negedge rst_n_sync) begin
    if (!rst_n_sync) irq_pipe <= '0;
    else             irq_pipe <= {irq_pipe[IRQ_PIPE_DEPTH-2:0], i_irq};
  end

  assign ev = irq_pipe[0] & ~irq_pipe[IRQ_PIPE_DEPTH-1];

  logic [NUM_CH-1:0] led_nxt;
  logic [NUM_CH-1:0] done_vec;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ch_state_t        state, state_nxt, base;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk or negedge rst_n_sync) begin
      if (!rst_n_sync) state <= CH_IDLE;
      else             state <= state_nxt;
    end

    // Clear is applied first so a coincident event lands on CH_DONE.
    always_comb begin
      base      = clr ? CH_IDLE : state;
      state_nxt = CH_IDLE;
      case (base)
        CH_IDLE:    state_nxt = ev[k] ? CH_DONE : CH_IDLE;
        CH_DONE:    state_nxt = ev[k] ? CH_OVERRUN : CH_DONE;
        CH_OVERRUN: state_nxt = CH_OVERRUN;
        default:    state_nxt = CH_IDLE;
      endcase
    end

    always_ff @(posedge i_clk or negedge rst_n_sync) begin
      if (!rst_n_sync) cnt <= '0;
      else if (ev[k])  cnt <= CNT_W'(sat_inc(32'(cnt), 32'({CNT_W{1'b1}})));
    end

    assign led_nxt[k]  = (state == CH_DONE) | ((state == CH_OVERRUN) & blink);
    assign done_vec[k] = (state == CH_DONE) | (state == CH_OVERRUN);
    assign o_done_count[k*CNT_W +: CNT_W] = cnt;
  end

  always_ff @(posedge i_clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      fpga_led        <= '0;
      o_all_done      <= 1'b0;
      o_heartbeat_led <= 1'b0;
    end else begin
      fpga_led        <= led_nxt;
      o_all_done      <= &done_vec;
      o_heartbeat_led <= blink;
    end
  end

endmodule
